// File: rtl/vector_dmem_responder.sv
// Word-serial memory responder: scalar and VEC_LEN-word bursts against an internal
// synchronous RAM, one access per cycle, one registered response beat per access.
module vector_dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned VEC_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_vector,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        rsp_err
);

  localparam int unsigned ADDR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(VEC_LEN);
  localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        base;
  logic               burst_we;
  logic               rd_ok;
  logic [31:0]        ram_q;
  logic [31:0]        mem [DEPTH];

  logic               beat_go;
  logic               beat_we;
  logic               beat_last;
  logic [32:0]        beat_addr;
  logic               beat_err;
  logic [ADDR_W-1:0]  idx;
  logic               wr_en;

  // Beat selection: a fresh request in IDLE, otherwise the next word of the burst.
  // The address keeps a carry bit so bursts running past 2^32 land out of range.
  always_comb begin
    beat_go   = 1'b0;
    beat_we   = 1'b0;
    beat_last = 1'b0;
    beat_addr = {1'b0, req_addr};
    if (state == IDLE) begin
      beat_go   = req_valid;
      beat_we   = req_we;
      beat_last = !req_vector;
    end else begin
      beat_go   = 1'b1;
      beat_we   = burst_we;
      beat_last = (cnt == LAST_CNT);
      beat_addr = {1'b0, base} + (33'(cnt) << 2);
    end
  end

  assign beat_err = (beat_addr[1:0] != 2'b00) || (beat_addr >= LIMIT);
  assign idx      = beat_addr[ADDR_W+1:2];
  assign wr_en    = beat_go && beat_we && !beat_err && !reset;

  // Storage is never reset; the read port returns pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= req_wdata;
    ram_q <= mem[idx];
  end

  assign rsp_rdata = rd_ok ? ram_q : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      burst_we  <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      rsp_valid <= beat_go;
      rsp_last  <= beat_go && beat_last;
      rsp_err   <= beat_go && beat_err;
      rd_ok     <= beat_go && !beat_we && !beat_err;
      case (state)
        IDLE: begin
          if (req_valid && req_vector) begin
            base      <= req_addr;
            burst_we  <= req_we;
            cnt       <= CNT_W'(1);
            req_ready <= 1'b0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (cnt == LAST_CNT) begin
            cnt       <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dmem_responder.sv
// Randomized scoreboard bench for vector_dmem_responder against an array-based memory model.
module tb_vector_dmem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned VEC_LEN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_vector;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_last;
  logic        rsp_err;

  vector_dmem_responder #(.DEPTH(DEPTH), .VEC_LEN(VEC_LEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_vector(req_vector), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
    bit          known;
    bit          last;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mmem   [DEPTH];
  bit          mknown [DEPTH];
  logic [31:0] wbuf   [VEC_LEN];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: one access at an unbounded byte address, expected response due next cycle.
  task automatic model_beat(input bit we, input logic [63:0] a, input logic [31:0] wd, input bit last);
    exp_t e;
    int   idx;
    e.due   = cyc + 1;
    e.last  = last;
    e.err   = (a[1:0] != 2'b00) || (a >= 64'(DEPTH) * 4);
    e.rdata = 32'h0;
    e.known = 1'b1;
    idx = int'((a >> 2) % 64'(DEPTH));
    if (!e.err) begin
      if (we) begin
        mmem[idx]   = wd;
        mknown[idx] = 1'b1;
      end else begin
        e.rdata = mmem[idx];
        e.known = mknown[idx];
      end
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_last !== e.last || rsp_err !== e.err ||
          (e.known && rsp_rdata !== e.rdata)) begin
        failures++;
        $display("FAIL beat cyc=%0d valid=%b/1 rdata=%h/%h(known=%0b) last=%b/%b err=%b/%b",
                 cyc, rsp_valid, rsp_rdata, e.rdata, e.known, rsp_last, e.last, rsp_err, e.err);
      end
    end else if (rsp_valid !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_beat cyc=%0d valid=%b rdata=%h", cyc, rsp_valid, rsp_rdata);
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request; wbuf supplies per-beat write data. abort_at < beat count resets mid-burst.
  task automatic do_req(input bit we, input bit vec, input logic [31:0] addr,
                        input bit noise, input int abort_at);
    int n;
    int guard;
    n = vec ? int'(VEC_LEN) : 1;
    guard = 0;
    if (!req_ready) req_valid = 1'b0;
    while (!req_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'h1);
      return;
    end
    for (int k = 0; k < n; k++) begin
      logic [63:0] a;
      a = 64'(addr) + 64'(4 * k);
      if (k == abort_at) begin
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_valid", 32'(rsp_valid), 32'h0);
        chk("abort_rdata", rsp_rdata, 32'h0);
        chk("abort_last_err", {30'h0, rsp_last, rsp_err}, 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        return;
      end
      if (k == 0) begin
        req_valid  = 1'b1;
        req_we     = we;
        req_vector = vec;
        req_addr   = addr;
      end else begin
        chk("ready_in_burst", 32'(req_ready), 32'h0);
        req_valid  = noise;
        req_we     = 1'b1;
        req_vector = 1'b0;
        req_addr   = 32'h0;
      end
      req_wdata = wbuf[k];
      model_beat(we, a, wbuf[k], k == n - 1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic fill(input logic [31:0] v0, input logic [31:0] step);
    for (int k = 0; k < int'(VEC_LEN); k++) wbuf[k] = v0 + step * 32'(k);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mknown[i] = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vector = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    chk("reset_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_last_err", {30'h0, rsp_last, rsp_err}, 32'h0);
    @(posedge clk); #1;
    chk("reset_ready", 32'(req_ready), 32'h1);

    // Scalar write then read-after-write.
    fill(32'hDEADBEEF, 0);
    do_req(1'b1, 1'b0, 32'h10, 1'b0, 99);
    do_req(1'b0, 1'b0, 32'h10, 1'b0, 99);
    idle(2);

    // Vector write then vector read.
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_req(1'b1, 1'b1, 32'h40, 1'b0, 99);
    do_req(1'b0, 1'b1, 32'h40, 1'b0, 99);
    idle(1);

    // Misaligned write leaves 0x40 intact; vector read crossing the top of memory.
    fill(32'hBAD0BAD0, 0);
    do_req(1'b1, 1'b0, 32'h41, 1'b0, 99);
    do_req(1'b0, 1'b0, 32'h40, 1'b0, 99);
    fill(32'hC000_0000, 1);
    do_req(1'b1, 1'b0, 32'hFF8, 1'b0, 99);
    fill(32'hC000_0001, 1);
    do_req(1'b1, 1'b0, 32'hFFC, 1'b0, 99);
    do_req(1'b0, 1'b1, 32'hFF8, 1'b0, 99);
    do_req(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 99);
    idle(1);

    // Vector read followed by a held scalar read, back-to-back.
    do_req(1'b0, 1'b1, 32'h40, 1'b0, 99);
    do_req(1'b0, 1'b0, 32'h10, 1'b0, 99);
    idle(1);

    // Reset in the middle of a vector write.
    fill(32'h5550, 1);
    do_req(1'b1, 1'b1, 32'h80, 1'b0, 99);
    fill(32'hA, 1);
    do_req(1'b1, 1'b1, 32'h80, 1'b0, 2);
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(req_ready), 32'h1);
    do_req(1'b0, 1'b1, 32'h80, 1'b0, 99);
    idle(1);

    // Requests pulsed during a burst are ignored.
    fill(32'h0000_0F00, 0);
    do_req(1'b1, 1'b0, 32'h0, 1'b0, 99);
    fill(32'h7777_0000, 1);
    do_req(1'b0, 1'b1, 32'h20, 1'b1, 99);
    do_req(1'b0, 1'b0, 32'h0, 1'b0, 99);
    idle(1);

    // Randomized traffic over a small hot window plus edge addresses.
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      int cls;
      cls = int'($urandom_range(0, 9));
      if (cls <= 5)      a = 32'($urandom_range(0, 63)) << 2;
      else if (cls == 6) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (cls == 7) a = 32'(DEPTH * 4) - (32'($urandom_range(1, 6)) << 2);
      else if (cls == 8) a = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else               a = $urandom;
      for (int k = 0; k < int'(VEC_LEN); k++) wbuf[k] = $urandom;
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
             1'($urandom_range(0, 1)), 99);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(1);
    for (int g = 0; g < 10 && sb.size() > 0; g++) idle(1);
    if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'h0);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
